// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants, decoder state type and frame helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVF0   = 8'h00;
  localparam logic [7:0] PS2_OVF1   = 8'hFF;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    SKIP = 1'b1
  } decState_t;

  // Device responses and overrun codes that never represent a key.
  function automatic logic isDiscard(input logic [7:0] code);
    case (code)
      PS2_ACK, PS2_BAT, PS2_ECHO, PS2_RESEND, PS2_OVF0, PS2_OVF1: isDiscard = 1'b1;
      default: isDiscard = 1'b0;
    endcase
  endfunction

  // Frame layout is {stop, parity, data[7:0], start}; parity is odd over data plus parity.
  function automatic logic frameOk(input logic [10:0] frame);
    frameOk = (frame[0] == 1'b0) && (frame[10] == 1'b1) && ((^frame[9:1]) == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_filter.sv
// Two-flop synchroniser followed by a stability filter for one PS/2 line.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic level
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic [1:0]    syncReg;
  logic [CW-1:0] stableCnt;

  // Bring the asynchronous pin into the clock domain; idle level is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncReg <= 2'b11;
    end else begin
      syncReg <= {syncReg[0], line};
    end
  end

  // Toggle the filtered level only after FILTER consecutive differing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level     <= 1'b1;
      stableCnt <= '0;
    end else if (syncReg[1] != level) begin
      if (stableCnt == CW'(FILTER - 1)) begin
        level     <= ~level;
        stableCnt <= '0;
      end else begin
        stableCnt <= stableCnt + CW'(1);
      end
    end else begin
      stableCnt <= '0;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: line conditioning, 11-bit deframing with watchdog,
// and a set-2 prefix decoder producing one strobe per make/break event.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 48000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2Dq,
  output logic       keyPrss,
  output logic       keyStrb,
  output logic [7:0] keyCode,
  output logic       keyExtd,
  output logic       frmErr
);

  logic        ckFilt, dqFilt, ckDly, dqSamp, fallEdge;
  logic [10:0] shiftReg, frameNext;
  logic [3:0]  bitCnt;
  logic [15:0] wdCnt;
  logic        byteValid;
  logic [7:0]  byteData;

  decState_t   state, stateNext;
  logic [2:0]  skipCnt, skipNext;
  logic        extFlag, extNext, brkFlag, brkNext;
  logic        strbNext, prssNext, extdNext;
  logic [7:0]  codeNext;

  ps2_filter #(.FILTER(FILTER)) ckFilter (
    .clock (clock),
    .reset (reset),
    .line  (ps2Ck),
    .level (ckFilt)
  );

  ps2_filter #(.FILTER(FILTER)) dqFilter (
    .clock (clock),
    .reset (reset),
    .line  (ps2Dq),
    .level (dqFilt)
  );

  // Registered falling-edge pulse, with data captured in the same cycle as the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ckDly    <= 1'b1;
      fallEdge <= 1'b0;
      dqSamp   <= 1'b1;
    end else begin
      ckDly    <= ckFilt;
      fallEdge <= ckDly & ~ckFilt;
      dqSamp   <= dqFilt;
    end
  end

  assign frameNext = {dqSamp, shiftReg[10:1]};

  // Deframer and watchdog; a falling edge takes priority over a timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shiftReg  <= '0;
      bitCnt    <= 4'd0;
      wdCnt     <= 16'd0;
      byteValid <= 1'b0;
      byteData  <= 8'h00;
      frmErr    <= 1'b0;
    end else begin
      byteValid <= 1'b0;
      frmErr    <= 1'b0;
      if (fallEdge) begin
        wdCnt    <= 16'd0;
        shiftReg <= frameNext;
        if (bitCnt == 4'd10) begin
          bitCnt    <= 4'd0;
          byteData  <= frameNext[8:1];
          byteValid <= frameOk(frameNext);
          frmErr    <= ~frameOk(frameNext);
        end else begin
          bitCnt <= bitCnt + 4'd1;
        end
      end else begin
        if (wdCnt != 16'hFFFF) begin
          wdCnt <= wdCnt + 16'd1;
        end
        if ((wdCnt >= 16'(TIMEOUT)) && (bitCnt != 4'd0)) begin
          bitCnt <= 4'd0;
        end
      end
    end
  end

  // Decoder state, prefix flags and the held key-event outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      skipCnt <= 3'd0;
      extFlag <= 1'b0;
      brkFlag <= 1'b0;
      keyStrb <= 1'b0;
      keyPrss <= 1'b0;
      keyExtd <= 1'b0;
      keyCode <= 8'h00;
    end else begin
      state   <= stateNext;
      skipCnt <= skipNext;
      extFlag <= extNext;
      brkFlag <= brkNext;
      keyStrb <= strbNext;
      keyPrss <= prssNext;
      keyExtd <= extdNext;
      keyCode <= codeNext;
    end
  end

  // Prefix resolution: E0/F0 accumulate flags, E1 swallows the pause sequence.
  always_comb begin
    stateNext = state;
    skipNext  = skipCnt;
    extNext   = extFlag;
    brkNext   = brkFlag;
    strbNext  = 1'b0;
    prssNext  = keyPrss;
    extdNext  = keyExtd;
    codeNext  = keyCode;
    case (state)
      IDLE: begin
        if (frmErr) begin
          extNext = 1'b0;
          brkNext = 1'b0;
        end else if (byteValid) begin
          if (byteData == PS2_EXT) begin
            extNext = 1'b1;
          end else if (byteData == PS2_BRK) begin
            brkNext = 1'b1;
          end else if (byteData == PS2_PAUSE) begin
            stateNext = SKIP;
            skipNext  = PAUSE_SKIP;
            extNext   = 1'b0;
            brkNext   = 1'b0;
          end else if (isDiscard(byteData)) begin
            extNext = 1'b0;
            brkNext = 1'b0;
          end else begin
            strbNext = 1'b1;
            prssNext = ~brkFlag;
            extdNext = extFlag;
            codeNext = byteData;
            extNext  = 1'b0;
            brkNext  = 1'b0;
          end
        end else begin
          stateNext = IDLE;
        end
      end
      SKIP: begin
        if (frmErr) begin
          stateNext = IDLE;
          skipNext  = 3'd0;
          extNext   = 1'b0;
          brkNext   = 1'b0;
        end else if (byteValid) begin
          skipNext = skipCnt - 3'd1;
          if (skipCnt == 3'd1) begin
            stateNext = IDLE;
          end else begin
            stateNext = SKIP;
          end
        end else begin
          stateNext = SKIP;
        end
      end
      default: begin
        stateNext = IDLE;
        skipNext  = 3'd0;
        extNext   = 1'b0;
        brkNext   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench: table of frames with a key-event scoreboard, plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int HALF_BIT = 20;
  localparam int TMO      = 300;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Ck = 1'b1;
  logic       ps2Dq = 1'b1;
  logic       keyPrss, keyStrb, keyExtd, frmErr;
  logic [7:0] keyCode;

  ps2_keyboard_rx #(.FILTER(8), .TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset   (reset),
    .ps2Ck   (ps2Ck),
    .ps2Dq   (ps2Dq),
    .keyPrss (keyPrss),
    .keyStrb (keyStrb),
    .keyCode (keyCode),
    .keyExtd (keyExtd),
    .frmErr  (frmErr)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       prss;
    logic       extd;
    logic [7:0] code;
  } ev_t;

  typedef struct {
    logic [7:0] code;
    logic       bad;
    logic       strb;
    logic       prss;
    logic       extd;
    logic       err;
  } vec_t;

  ev_t expQ[$];
  ev_t obsQ[$];
  int  errSeen = 0;
  int  errExp  = 0;
  int  checks  = 0;
  int  passed  = 0;

  // Monitor: record every strobe and frame error, sampled away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (keyStrb) obsQ.push_back(ev_t'({keyPrss, keyExtd, keyCode}));
      if (frmErr) errSeen++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [10:0] mkFrame(input logic [7:0] b, input logic bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic sendBits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      ps2Dq = frame[i];
      cyc(HALF_BIT);
      ps2Ck = 1'b0;
      cyc(HALF_BIT);
      ps2Ck = 1'b1;
    end
    ps2Dq = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic bad);
    sendBits(mkFrame(b, bad), 11);
    cyc(40);
  endtask

  task automatic expectKey(input logic prss, input logic extd, input logic [7:0] code);
    ev_t e;
    e.prss = prss;
    e.extd = extd;
    e.code = code;
    expQ.push_back(e);
  endtask

  task automatic checkEvents(input string name);
    ev_t e, o;
    check({name, " strobe count"}, 32'(obsQ.size()), 32'(expQ.size()));
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      check({name, " event {prss,extd,code}"}, 32'(o), 32'(e));
    end
    expQ.delete();
    obsQ.delete();
    check({name, " frmErr count"}, 32'(errSeen), 32'(errExp));
  endtask

  task automatic checkReset(input string name);
    check({name, " keyPrss"}, 32'(keyPrss), 32'd0);
    check({name, " keyStrb"}, 32'(keyStrb), 32'd0);
    check({name, " keyCode"}, 32'(keyCode), 32'd0);
    check({name, " keyExtd"}, 32'(keyExtd), 32'd0);
    check({name, " frmErr"}, 32'(frmErr), 32'd0);
  endtask

  vec_t vecs[14];

  initial begin
    #5_000_000;
    $display("FAIL time limit: simulation did not finish, checks so far %0d", checks);
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h75, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h29, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    cyc(5);
    checkReset("reset");
    reset = 1'b0;
    cyc(20);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].strb) expectKey(vecs[i].prss, vecs[i].extd, vecs[i].code);
      if (vecs[i].err) errExp++;
      sendByte(vecs[i].code, vecs[i].bad);
      checkEvents($sformatf("row%0d byte %02h", i, vecs[i].code));
    end

    // Partial frame abandoned by the watchdog, then a clean frame.
    sendBits(mkFrame(8'h55, 1'b0), 5);
    cyc(TMO + 100);
    expectKey(1'b1, 1'b0, 8'h29);
    sendByte(8'h29, 1'b0);
    checkEvents("watchdog");

    // Short clock glitch must not shift a bit.
    ps2Ck = 1'b0;
    cyc(3);
    ps2Ck = 1'b1;
    cyc(40);
    expectKey(1'b1, 1'b0, 8'h1C);
    sendByte(8'h1C, 1'b0);
    checkEvents("glitch");

    // Pause sequence is swallowed whole; the following key decodes normally.
    sendByte(8'hE1, 1'b0);
    sendByte(8'h14, 1'b0);
    sendByte(8'h77, 1'b0);
    sendByte(8'hE1, 1'b0);
    sendByte(8'hF0, 1'b0);
    sendByte(8'h14, 1'b0);
    sendByte(8'hF0, 1'b0);
    sendByte(8'h77, 1'b0);
    checkEvents("pause body");
    expectKey(1'b1, 1'b0, 8'h5A);
    sendByte(8'h5A, 1'b0);
    checkEvents("after pause");

    // Reset mid-frame returns outputs to reset values; next frame decodes.
    sendBits(mkFrame(8'h33, 1'b0), 4);
    reset = 1'b1;
    cyc(3);
    checkReset("mid-frame reset");
    reset = 1'b0;
    cyc(20);
    expectKey(1'b1, 1'b0, 8'h1C);
    sendByte(8'h1C, 1'b0);
    checkEvents("after reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
